// File: rtl/move_commit_ctrl.sv
// move_commit_ctrl: reads a board point, commits the current player's piece if it is empty, and reports the result.
// Optional turn-forfeit timer is enabled by defining MOVE_TIMEOUT_EN.
module move_commit_ctrl #(
    parameter int BOARD_SIZE     = 15,
    parameter int COORD_W        = 5,
    parameter int ADDR_W         = 8,
    parameter int CNT_W          = 9,
    parameter int RD_LAT         = 1,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [COORD_W-1:0] req_x,
    input  logic [COORD_W-1:0] req_y,
    input  logic               game_over,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_rd_en,
    output logic               mem_wr_en,
    output logic [1:0]         mem_wr_data,
    input  logic               point_writable,
    output logic               resp_valid,
    output logic               resp_ok,
    output logic [1:0]         resp_code,
    output logic [1:0]         player,
    output logic [CNT_W-1:0]   piece_count,
    output logic               board_full,
    output logic               timeout_pulse
);
    localparam int MAXP  = BOARD_SIZE * BOARD_SIZE;
    localparam int LAT_W = RD_LAT > 1 ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {IDLE, READ, WAIT, CHECK, WRITE, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_rd_en_q, mem_rd_en_d, mem_wr_en_q, mem_wr_en_d;
    logic [1:0]        mem_wr_data_q, mem_wr_data_d;
    logic              resp_valid_q, resp_valid_d, resp_ok_q, resp_ok_d;
    logic [1:0]        resp_code_q, resp_code_d, player_q, player_d;
    logic [CNT_W-1:0]  piece_count_q, piece_count_d;
    logic              board_full_q, board_full_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic              hs, out_of_range, expire;

    assign req_ready    = (state_q == IDLE) && !game_over;
    assign hs           = req_valid && req_ready;
    assign out_of_range = 32'(req_x) >= BOARD_SIZE || 32'(req_y) >= BOARD_SIZE;

    always_comb begin
        state_d       = state_q;
        mem_addr_d    = mem_addr_q;
        mem_rd_en_d   = 1'b0;
        mem_wr_en_d   = 1'b0;
        mem_wr_data_d = mem_wr_data_q;
        resp_code_d   = resp_code_q;
        player_d      = player_q;
        piece_count_d = piece_count_q;
        lat_d         = lat_q;
        case (state_q)
            IDLE: if (hs) begin
                if (out_of_range) begin
                    state_d     = DONE;
                    resp_code_d = 2'b10;
                end else if (board_full_q) begin
                    state_d     = DONE;
                    resp_code_d = 2'b11;
                end else begin
                    state_d     = READ;
                    mem_rd_en_d = 1'b1;
                    mem_addr_d  = ADDR_W'(32'(req_y) * BOARD_SIZE + 32'(req_x));
                end
            end
            READ: begin
                state_d = RD_LAT > 1 ? WAIT : CHECK;
                lat_d   = LAT_W'(RD_LAT - 2);
            end
            WAIT: begin
                state_d = lat_q == '0 ? CHECK : WAIT;
                lat_d   = lat_q - 1'b1;
            end
            CHECK: if (point_writable) begin
                state_d       = WRITE;
                mem_wr_en_d   = 1'b1;
                mem_wr_data_d = player_q;
            end else begin
                state_d     = DONE;
                resp_code_d = 2'b01;
            end
            WRITE: begin
                state_d     = DONE;
                resp_code_d = 2'b00;
            end
            DONE: begin
                state_d = IDLE;
                if (resp_code_q == 2'b00) begin
                    player_d      = ~player_q;
                    piece_count_d = piece_count_q == CNT_W'(MAXP) ? piece_count_q : piece_count_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (expire) player_d = ~player_q;
        resp_valid_d = state_d == DONE;
        resp_ok_d    = state_d == DONE ? resp_code_d == 2'b00 : resp_ok_q;
        board_full_d = piece_count_d == CNT_W'(MAXP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            mem_addr_q    <= '0;
            mem_rd_en_q   <= 1'b0;
            mem_wr_en_q   <= 1'b0;
            mem_wr_data_q <= 2'b00;
            resp_valid_q  <= 1'b0;
            resp_ok_q     <= 1'b0;
            resp_code_q   <= 2'b00;
            player_q      <= 2'b01;
            piece_count_q <= '0;
            board_full_q  <= 1'b0;
            lat_q         <= '0;
        end else begin
            state_q       <= state_d;
            mem_addr_q    <= mem_addr_d;
            mem_rd_en_q   <= mem_rd_en_d;
            mem_wr_en_q   <= mem_wr_en_d;
            mem_wr_data_q <= mem_wr_data_d;
            resp_valid_q  <= resp_valid_d;
            resp_ok_q     <= resp_ok_d;
            resp_code_q   <= resp_code_d;
            player_q      <= player_d;
            piece_count_q <= piece_count_d;
            board_full_q  <= board_full_d;
            lat_q         <= lat_d;
        end
    end

`ifdef MOVE_TIMEOUT_EN
    localparam int TMR_W = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             timeout_pulse_q;
    // a handshake in the expiry cycle wins, so expiry requires no pending request
    assign expire = req_ready && !req_valid && tmr_q == TMR_W'(TIMEOUT_CYCLES - 1);
    always_comb tmr_d = (hs || expire || state_q == DONE) ? '0 : req_ready ? tmr_q + 1'b1 : tmr_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmr_q           <= '0;
            timeout_pulse_q <= 1'b0;
        end else begin
            tmr_q           <= tmr_d;
            timeout_pulse_q <= expire;
        end
    end
    assign timeout_pulse = timeout_pulse_q;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign expire        = 1'b0;
    assign timeout_pulse = 1'b0;
`endif

    assign mem_addr    = mem_addr_q;
    assign mem_rd_en   = mem_rd_en_q;
    assign mem_wr_en   = mem_wr_en_q;
    assign mem_wr_data = mem_wr_data_q;
    assign resp_valid  = resp_valid_q;
    assign resp_ok     = resp_ok_q;
    assign resp_code   = resp_code_q;
    assign player      = player_q;
    assign piece_count = piece_count_q;
    assign board_full  = board_full_q;
endmodule

// File: doc/move_commit_ctrl.md
Name: move_commit_ctrl

Overview:
- Sequences one player move into the game-board memory.
- Accepts a move request (x,y) and reads the point's state from board RAM.
- Consumes the point-writable flag from the enable-control stage, which is driven from that read data, and writes the current player's piece only if the flag is high.
- Tracks whose turn it is, counts placed pieces and reports accept/reject status to the game FSM upstream.

Parameters:
- BOARD_SIZE, 15, points per board side.
- COORD_W, 5, width of the x and y coordinates.
- ADDR_W, 8, board RAM address width. Must satisfy 2^ADDR_W >= BOARD_SIZE*BOARD_SIZE.
- CNT_W, 9, width of the placed-piece counter.
- RD_LAT, 1, board RAM read latency in cycles, >=1.
- TIMEOUT_CYCLES, 50000000, idle cycles before a turn is forfeited. Used only with the optional feature.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  move request present.
- req_ready  out  1  block can accept a request.
- req_x  in  COORD_W  column.
- req_y  in  COORD_W  row.
- game_over  in  1  freezes acceptance of new requests.
- mem_addr  out  ADDR_W  board RAM address.
- mem_rd_en  out  1  read strobe.
- mem_wr_en  out  1  write strobe.
- mem_wr_data  out  2  piece written (01 black, 10 white).
- point_writable  in  1  1 = addressed point empty; valid RD_LAT cycles after mem_rd_en.
- resp_valid  out  1  one-cycle result pulse.
- resp_ok  out  1  1 = piece placed.
- resp_code  out  2  00 ok, 01 occupied, 10 out of range, 11 board full.
- player  out  2  side to move.
- piece_count  out  CNT_W  pieces on board.
- board_full  out  1  piece_count == BOARD_SIZE*BOARD_SIZE.
- timeout_pulse  out  1  turn forfeited (optional feature only).

Behaviour:
- Reset (async, any state) values:
  - Next state is IDLE.
  - player=01; piece_count=0.
  - All strobes, resp_valid, resp_ok and timeout_pulse =0.
  - resp_code=00; mem_addr=0.
  - An in-flight write is abandoned; no mem_wr_en follows reset.
- req_ready = (state==IDLE) & ~game_over. It is combinational from state and game_over only.
- Handshake is valid & ready in the same cycle (cycle T). x and y are latched at T. No backpressure on resp_valid.
- States: IDLE, READ, WAIT, CHECK, WRITE, DONE.
- IDLE, on handshake:
  - x>=BOARD_SIZE or y>=BOARD_SIZE: go to DONE with code 10. No memory access.
  - Else if board_full: go to DONE with code 11.
  - Else: go to READ.
- READ: mem_rd_en=1 for exactly one cycle (T+1). mem_addr = y*BOARD_SIZE + x, truncated to ADDR_W, registered from the latched coordinates. mem_addr holds until the next request is accepted.
- WAIT: entered only when RD_LAT>1. Stays RD_LAT-1 cycles (internal down-counter).
- CHECK: samples point_writable at cycle T+1+RD_LAT.
  - 1: go to WRITE.
  - 0: go to DONE with code 01.
- WRITE: mem_wr_en=1 for one cycle with mem_wr_data=player. Then go to DONE with code 00.
- DONE: resp_valid=1 for one cycle. resp_ok=(code==00). resp_code is held until the next DONE. Return to IDLE.
  - On code 00, in the DONE cycle: player toggles (01<->10) and piece_count increments.
  - On any other code, player and piece_count are unchanged.
- Latency with RD_LAT=1, request accepted at T:
  - out of range / full: resp at T+1.
  - occupied: resp at T+3.
  - placed: write at T+3, resp at T+4.
- mem_rd_en and mem_wr_en are never high in the same cycle.
- piece_count saturates at BOARD_SIZE*BOARD_SIZE. board_full is registered and updates with piece_count.
- game_over rising mid-operation does not abort the current move. It only blocks the next acceptance.

Optional Feature:
- Macro: MOVE_TIMEOUT_EN.
- Enabled:
  - A turn timer counts cycles while in IDLE and ~game_over.
  - The timer clears on any handshake, on any DONE and on reset.
  - When it reaches TIMEOUT_CYCLES-1: timeout_pulse=1 for one cycle, player toggles, timer clears.
  - If a handshake occurs in that same cycle, the handshake wins: no timeout and no toggle.
- Disabled: timer logic absent; timeout_pulse tied 0.

Test Plan:
- Reset, then request (3,4) with point_writable=1 at T+2 → mem_rd_en at T+1 with mem_addr=63; mem_wr_en at T+3 with mem_wr_data=01; resp_valid at T+4 with ok=1, code=00; player=10; piece_count=1.
- Request (3,4) again with point_writable=0 → no mem_wr_en; resp at T+3 with ok=0, code=01; player stays 10; count stays 1.
- Request (15,2) → no mem_rd_en; resp at T+1 with code=10; state unchanged.
- Fill all 225 points with legal moves → board_full=1, piece_count=225. The next request returns code 11 at T+1.
- Assert reset during WRITE-bound CHECK (point_writable=1 at T+2, reset at T+2) → no mem_wr_en; player=01, count=0, req_ready=1 after release.
- With MOVE_TIMEOUT_EN, TIMEOUT_CYCLES=8, idle 8 cycles → timeout_pulse once, player 01→10. A request issued at cycle 7 instead suppresses the pulse.
